// File: rtl/piso_scan16_pkg.sv
// Shared types and constants for the 16-bit parallel-in/serial-out scanner.
// Select start/end points depend on the scan direction.
package piso_scan16_pkg;

  localparam int SEL_W  = 4;
  localparam int WORD_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
    return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
    return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
  endfunction

endpackage

// File: rtl/piso_scan16_if.sv
// Word-load handshake, serial-out stream and debug taps of the scanner.
// master = environment (source + sink), slave = scanner.
interface piso_scan16_if;
  import piso_scan16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic              out_last;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_last, sel, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_last, sel, busy
  );

endinterface

// File: rtl/piso_scan16_mux16.sv
// Structural 16:1 bit mux built as a four-level tree of 2:1 selects.
module mux16
  import piso_scan16_pkg::*;
(
  input  logic [WORD_W-1:0] X,
  input  logic [SEL_W-1:0]  sel,
  output logic              Y
);

  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;

  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = sel[0] ? X[2*i+1] : X[2*i];
  end

  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
  end

  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = sel[2] ? l2[2*i+1] : l2[2*i];
  end

  assign Y = sel[3] ? l3[1] : l3[0];

endmodule

// File: rtl/piso_scan16.sv
// Parallel-in/serial-out scanner: latches a 16-bit word and walks sel through
// mux16, presenting one bit per accepted transfer on a valid/ready stream.
module piso_scan16
  import piso_scan16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit B2B       = 1'b1
)(
  input  logic            clk,
  input  logic            rst,
  piso_scan16_if.slave    bus
);

  localparam logic [SEL_W-1:0] START = sel_start(MSB_FIRST);
  localparam logic [SEL_W-1:0] END   = sel_end(MSB_FIRST);

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [SEL_W-1:0]  sel_q;
  logic              out_bit;
  logic              scan;
  logic              last;
  logic              xfer;
  logic              in_ready;
  logic              load;

  assign scan = (state == ST_SCAN);
  assign last = scan && (sel_q == END);
  assign xfer = scan && bus.out_ready;

  // The final-bit transfer may also open the load window so words run back to back.
  assign in_ready = !rst && (!scan || (B2B && xfer && last));
  assign load     = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      word_q <= '0;
      sel_q  <= START;
    end else if (load) begin
      state  <= ST_SCAN;
      word_q <= bus.in_data;
      sel_q  <= START;
    end else if (xfer) begin
      if (last) begin
        state <= ST_IDLE;
        sel_q <= START;
      end else if (MSB_FIRST) begin
        sel_q <= sel_q - 1'b1;
      end else begin
        sel_q <= sel_q + 1'b1;
      end
    end
  end

  mux16 u_mux (
    .Y   (out_bit),
    .X   (word_q),
    .sel (sel_q)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = scan;
  assign bus.out_bit   = out_bit;
  assign bus.out_last  = last;
  assign bus.sel       = sel_q;
  assign bus.busy      = scan;

endmodule

// File: tb/tb_piso_scan16.sv
// Bench for piso_scan16: three instances (LSB-first B2B, MSB-first B2B,
// LSB-first non-B2B) checked cycle by cycle against a word/bit-index model.
module tb_piso_scan16;

  logic clk;
  logic rst;

  logic        iv[3];
  logic [15:0] idat[3];
  logic        ordy[3];
  logic        ov[3], ir[3], ob[3], ol[3], bz[3];
  logic [3:0]  sl[3];

  piso_scan16_if bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].in_valid  = iv[g];
    assign bus[g].in_data   = idat[g];
    assign bus[g].out_ready = ordy[g];
    assign ov[g] = bus[g].out_valid;
    assign ir[g] = bus[g].in_ready;
    assign ob[g] = bus[g].out_bit;
    assign ol[g] = bus[g].out_last;
    assign sl[g] = bus[g].sel;
    assign bz[g] = bus[g].busy;

    piso_scan16 #(.MSB_FIRST(g == 1), .B2B(g != 2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: is a word in flight, which word, how many of its bits have gone.
  bit          m_busy[3];
  logic [15:0] m_word[3];
  int          m_idx[3];

  logic [63:0] rec[3];
  int          rec_n[3];
  int          acc_n[3];

  function automatic bit msb_of(input int d);
    return d == 1;
  endfunction

  function automatic bit b2b_of(input int d);
    return d != 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 1'b0;
      m_word[d] = 16'h0000;
      m_idx[d]  = 0;
    end
  endtask

  task automatic clear_rec();
    for (int d = 0; d < 3; d++) begin
      rec[d]   = '0;
      rec_n[d] = 0;
      acc_n[d] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      idat[d] = 16'h0000;
      ordy[d] = 1'b0;
    end
  endtask

  // One clock: check every instance at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit          nb[3];
    logic [15:0] nw[3];
    int          ni[3];
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      int es;
      bit exfer, elast, eready;
      es     = m_busy[d] ? (msb_of(d) ? 15 - m_idx[d] : m_idx[d]) : (msb_of(d) ? 15 : 0);
      elast  = m_busy[d] && (m_idx[d] == 15);
      exfer  = m_busy[d] && ordy[d];
      eready = !rst && (!m_busy[d] || (b2b_of(d) && exfer && elast));
      chk($sformatf("d%0d out_valid", d), ov[d], m_busy[d]);
      chk($sformatf("d%0d busy", d), bz[d], m_busy[d]);
      chk($sformatf("d%0d sel", d), sl[d], es);
      chk($sformatf("d%0d out_last", d), ol[d], elast);
      chk($sformatf("d%0d in_ready", d), ir[d], eready);
      if (m_busy[d]) chk($sformatf("d%0d out_bit", d), ob[d], m_word[d][es]);
      if (ov[d] && ordy[d] && rec_n[d] < 64) begin
        rec[d][rec_n[d]] = ob[d];
        rec_n[d]++;
      end
      if (iv[d] && ir[d]) acc_n[d]++;
      nb[d] = m_busy[d];
      nw[d] = m_word[d];
      ni[d] = m_idx[d];
      if (exfer) begin
        if (elast) begin
          ni[d] = 0;
          if (b2b_of(d) && iv[d]) nw[d] = idat[d];
          else nb[d] = 1'b0;
        end else begin
          ni[d] = m_idx[d] + 1;
        end
      end else if (!m_busy[d] && iv[d] && !rst) begin
        nb[d] = 1'b1;
        nw[d] = idat[d];
        ni[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      for (int d = 0; d < 3; d++) begin
        m_busy[d] = nb[d];
        m_word[d] = nw[d];
        m_idx[d]  = ni[d];
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stall;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    clear_rec();
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle in_ready", ir[0], 1'b1);
    chk("idle sel lsb", sl[0], 4'd0);
    chk("idle sel msb", sl[1], 4'd15);

    // LSB-first 16'hA5C3
    clear_rec();
    idat[0] = 16'hA5C3; iv[0] = 1'b1; ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0; n = 1;
    while (rec_n[0] < 16 && n < 40) begin step(); n++; end
    chk("a5c3 bits", rec[0][15:0], 16'hA5C3);
    chk("a5c3 cycles", n, 17);
    step();

    // MSB-first 16'h8001
    clear_rec();
    idat[1] = 16'h8001; iv[1] = 1'b1; ordy[1] = 1'b1;
    step();
    iv[1] = 1'b0; n = 1;
    while (rec_n[1] < 16 && n < 40) begin step(); n++; end
    chk("8001 first bit", rec[1][0], 1'b1);
    chk("8001 middle bits", rec[1][14:1], 14'h0);
    chk("8001 last bit", rec[1][15], 1'b1);
    chk("8001 cycles", n, 17);
    step();

    // 16'hFFFF with a 5-cycle sink stall at bit 4
    clear_rec();
    idat[0] = 16'hFFFF; iv[0] = 1'b1; ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0; n = 1; stall = 0;
    while (rec_n[0] < 16 && n < 60) begin
      if (rec_n[0] == 4 && stall < 5) begin
        ordy[0] = 1'b0;
        stall++;
        chk("stall sel", sl[0], 4'd4);
        chk("stall valid", ov[0], 1'b1);
      end else begin
        ordy[0] = 1'b1;
      end
      step(); n++;
    end
    chk("stall cycles", n, 22);
    step(); step(); step();
    chk("stall transfers", rec_n[0], 16);
    chk("stall bits", rec[0][15:0], 16'hFFFF);

    // Back-to-back 0x0001 then 0x8000: B2B instance vs non-B2B instance
    for (int d = 0; d < 3; d += 2) begin
      clear_rec();
      ordy[d] = 1'b1; n = 0;
      while (rec_n[d] < 32 && n < 100) begin
        iv[d]   = (acc_n[d] < 2);
        idat[d] = (acc_n[d] == 0) ? 16'h0001 : 16'h8000;
        step(); n++;
      end
      iv[d] = 1'b0;
      chk($sformatf("d%0d b2b bits", d), rec[d][31:0], 32'h8000_0001);
      chk($sformatf("d%0d b2b cycles", d), n, (d == 0) ? 33 : 34);
      step();
    end

    // Asynchronous reset at bit 7 of 16'h1234
    clear_rec();
    idat[0] = 16'h1234; iv[0] = 1'b1; ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0; n = 1;
    while (rec_n[0] < 7 && n < 40) begin step(); n++; end
    chk("pre-reset sel", sl[0], 4'd7);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst out_valid", ov[0], 1'b0);
    chk("rst busy", bz[0], 1'b0);
    chk("rst in_ready", ir[0], 1'b0);
    chk("rst sel", sl[0], 4'd0);
    step();
    rst = 1'b0;
    step(); step();
    chk("post-reset no bits", rec_n[0], 7);
    clear_rec();
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0; n = 1;
    while (rec_n[0] < 16 && n < 40) begin step(); n++; end
    chk("post-reset word", rec[0][15:0], 16'h1234);
    step();

    // Random traffic on all instances
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = $urandom_range(0, 1) == 1;
        idat[d] = 16'($urandom);
        ordy[d] = $urandom_range(0, 3) != 0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
